// File: rtl/ber_pkg.sv
// ============================================================================
// Module : ber_pkg
// Brief  : State encoding, mode codes and defaults shared by the BER sweep
//          controller and the BER datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ber_pkg;

    localparam logic [2:0] St_Idle   = 3'd0;
    localparam logic [2:0] St_Settle = 3'd1;
    localparam logic [2:0] St_Clear  = 3'd2;
    localparam logic [2:0] St_Count  = 3'd3;
    localparam logic [2:0] St_Drain  = 3'd4;
    localparam logic [2:0] St_Report = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = St_Idle,
        ST_SETTLE = St_Settle,
        ST_CLEAR  = St_Clear,
        ST_COUNT  = St_Count,
        ST_DRAIN  = St_Drain,
        ST_REPORT = St_Report
    } state_e;

    localparam logic Mode_Ones = 1'b0;
    localparam logic Mode_BER  = 1'b1;

    localparam int Def_DrainCycles = 4;

endpackage

`default_nettype wire

// File: rtl/ber_down_counter.sv
// ============================================================================
// Module : ber_down_counter
// Brief  : Loadable down-counter that stops at zero and flags it.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ber_down_counter #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ber_sweep_ctrl.sv
// ============================================================================
// Module : ber_sweep_ctrl
// Brief  : Steps the BER backend through a sweep of point codes and hands
//          each captured count to the readout. Optional early stop on error
//          limit is built when BER_EARLY_STOP_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ber_sweep_ctrl
    import ber_pkg::*;
#(
    parameter int CountWidth  = 41,
    parameter int PtWidth     = 8,
    parameter int WinWidth    = 32,
    parameter int DrainCycles = Def_DrainCycles
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_mode,
    input  logic [PtWidth-1:0]    cfg_first_pt,
    input  logic [PtWidth-1:0]    cfg_last_pt,
    input  logic [WinWidth-1:0]   cfg_settle,
    input  logic [WinWidth-1:0]   cfg_window,
    input  logic [CountWidth-1:0] cfg_err_limit,
    input  logic [CountWidth-1:0] ber_count,
    output logic [PtWidth-1:0]    point_code,
    output logic                  ber_mode,
    output logic                  ber_enable,
    output logic                  ber_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [PtWidth-1:0]    res_point,
    output logic [CountWidth-1:0] res_count,
    output logic                  res_early
);

    localparam int                    DrainWidth = $clog2(DrainCycles + 1);
    localparam logic [DrainWidth-1:0] DrainLoad  = DrainWidth'(DrainCycles - 1);

    state_e                state_q;
    logic                  mode_q;
    logic [PtWidth-1:0]    last_q;
    logic [PtWidth-1:0]    point_q;
    logic [WinWidth-1:0]   settle_q;
    logic [WinWidth-1:0]   window_q;
    logic [PtWidth-1:0]    res_point_q;
    logic [CountWidth-1:0] res_count_q;
    logic                  enable_q;
    logic                  clear_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  valid_q;
    logic                  early_q;
    logic                  res_early_q;

    logic [WinWidth-1:0]   settle_src;
    logic [WinWidth-1:0]   settle_load_val;
    logic [WinWidth-1:0]   window_load_val;
    logic                  settle_zero;
    logic                  window_zero;
    logic                  drain_zero;
    logic                  early_hit;

    // Counters are loaded with length-1 so a state lasts max(length,1) cycles.
    function automatic logic [WinWidth-1:0] arm(input logic [WinWidth-1:0] n);
        return (n == '0) ? '0 : n - WinWidth'(1);
    endfunction

    assign settle_src      = (state_q == ST_IDLE) ? cfg_settle : settle_q;
    assign settle_load_val = arm(settle_src);
    assign window_load_val = arm(window_q);

    ber_down_counter #(.Width(WinWidth)) u_settle_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_q != ST_SETTLE),
        .dec_i      (state_q == ST_SETTLE),
        .load_val_i (settle_load_val),
        .zero_o     (settle_zero)
    );

    ber_down_counter #(.Width(WinWidth)) u_window_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_q != ST_COUNT),
        .dec_i      (state_q == ST_COUNT),
        .load_val_i (window_load_val),
        .zero_o     (window_zero)
    );

    ber_down_counter #(.Width(DrainWidth)) u_drain_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (state_q != ST_DRAIN),
        .dec_i      (state_q == ST_DRAIN),
        .load_val_i (DrainLoad),
        .zero_o     (drain_zero)
    );

`ifdef BER_EARLY_STOP_EN
    logic [CountWidth-1:0] limit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            limit_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            limit_q <= cfg_err_limit;
        end
    end

    assign early_hit = (limit_q != '0) && (ber_count >= limit_q);
`else
    logic unused_err_limit;
    assign unused_err_limit = ^cfg_err_limit;
    assign early_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= Mode_Ones;
            last_q      <= '0;
            point_q     <= '0;
            settle_q    <= '0;
            window_q    <= '0;
            res_point_q <= '0;
            res_count_q <= '0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            early_q     <= 1'b0;
            res_early_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q  <= ST_IDLE;
                enable_q <= 1'b0;
                clear_q  <= 1'b0;
                valid_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            mode_q   <= cfg_mode;
                            last_q   <= cfg_last_pt;
                            settle_q <= cfg_settle;
                            window_q <= cfg_window;
                            point_q  <= cfg_first_pt;
                            busy_q   <= 1'b1;
                            state_q  <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_zero) begin
                            clear_q <= 1'b1;
                            early_q <= 1'b0;
                            state_q <= ST_CLEAR;
                        end
                    end
                    ST_CLEAR: begin
                        clear_q  <= 1'b0;
                        enable_q <= 1'b1;
                        state_q  <= ST_COUNT;
                    end
                    ST_COUNT: begin
                        if (window_zero || early_hit) begin
                            enable_q <= 1'b0;
                            early_q  <= early_hit;
                            state_q  <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_zero) begin
                            res_count_q <= ber_count;
                            res_point_q <= point_q;
                            res_early_q <= early_q;
                            valid_q     <= 1'b1;
                            state_q     <= ST_REPORT;
                        end
                    end
                    ST_REPORT: begin
                        if (res_ready) begin
                            valid_q <= 1'b0;
                            // >= also ends a first>last sweep after its single point.
                            if (point_q >= last_q) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                point_q <= point_q + PtWidth'(1);
                                state_q <= ST_SETTLE;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                        clear_q  <= 1'b0;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign point_code = point_q;
    assign ber_mode   = mode_q;
    assign ber_enable = enable_q;
    assign ber_clear  = clear_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign res_valid  = valid_q;
    assign res_point  = res_point_q;
    assign res_count  = res_count_q;
    assign res_early  = res_early_q;

endmodule

`default_nettype wire

// File: tb/tb_ber_sweep_ctrl.sv
// ============================================================================
// Module : tb_ber_sweep_ctrl
// Brief  : Directed self-checking bench for ber_sweep_ctrl with a simple
//          counting model standing in for the BER datapath.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ber_sweep_ctrl;

    localparam int CountWidth = 41;
    localparam int PtWidth    = 8;
    localparam int WinWidth   = 32;

    logic                  clk;
    logic                  reset_n;
    logic                  start;
    logic                  abort;
    logic                  cfg_mode;
    logic [PtWidth-1:0]    cfg_first_pt;
    logic [PtWidth-1:0]    cfg_last_pt;
    logic [WinWidth-1:0]   cfg_settle;
    logic [WinWidth-1:0]   cfg_window;
    logic [CountWidth-1:0] cfg_err_limit;
    logic [CountWidth-1:0] ber_count;
    logic [PtWidth-1:0]    point_code;
    logic                  ber_mode;
    logic                  ber_enable;
    logic                  ber_clear;
    logic                  busy;
    logic                  done;
    logic                  res_valid;
    logic                  res_ready;
    logic [PtWidth-1:0]    res_point;
    logic [CountWidth-1:0] res_count;
    logic                  res_early;

    logic [CountWidth-1:0] model_inc;

    int checks = 0;
    int errors = 0;

    int n_clear, first_clear, n_en, first_en, last_en;
    int first_valid, n_valid, n_done, k_done, busy_gap, n_res;
    logic [PtWidth-1:0]    res_pts  [8];
    logic [CountWidth-1:0] res_cnts [8];
    logic                  res_ers  [8];

    ber_sweep_ctrl #(
        .CountWidth (CountWidth),
        .PtWidth    (PtWidth),
        .WinWidth   (WinWidth),
        .DrainCycles(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .cfg_mode     (cfg_mode),
        .cfg_first_pt (cfg_first_pt),
        .cfg_last_pt  (cfg_last_pt),
        .cfg_settle   (cfg_settle),
        .cfg_window   (cfg_window),
        .cfg_err_limit(cfg_err_limit),
        .ber_count    (ber_count),
        .point_code   (point_code),
        .ber_mode     (ber_mode),
        .ber_enable   (ber_enable),
        .ber_clear    (ber_clear),
        .busy         (busy),
        .done         (done),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_point    (res_point),
        .res_count    (res_count),
        .res_early    (res_early)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: cleared by ber_clear, adds model_inc per enabled cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        ber_count <= '0;
        else if (ber_clear)  ber_count <= '0;
        else if (ber_enable) ber_count <= ber_count + model_inc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs until done (bounded), recording per-cycle activity; k=1 is the
    // first negedge after the edge that sees start.
    task automatic run_sweep(input bit with_start, input int bound);
        int k;
        n_clear = 0; first_clear = -1; n_en = 0; first_en = -1; last_en = -1;
        first_valid = -1; n_valid = 0; n_done = 0; k_done = -1; busy_gap = 0; n_res = 0;
        if (with_start) start = 1'b1;
        k = 0;
        while ((n_done == 0) && (k < bound)) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (ber_clear) begin
                n_clear++;
                if (first_clear < 0) first_clear = k;
            end
            if (ber_enable) begin
                n_en++;
                if (first_en < 0) first_en = k;
                last_en = k;
            end
            if (res_valid) begin
                n_valid++;
                if (first_valid < 0) first_valid = k;
                if (res_ready && (n_res < 8)) begin
                    res_pts[n_res]  = res_point;
                    res_cnts[n_res] = res_count;
                    res_ers[n_res]  = res_early;
                    n_res++;
                end
            end
            if (done) begin
                n_done++;
                k_done = k;
            end else if (!busy) begin
                busy_gap++;
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("done_pulse_once", 64'(n_done), 64'd1);
    endtask

    logic [63:0] all_outs;
    assign all_outs = {point_code, ber_mode, ber_enable, ber_clear, busy, done,
                       res_valid, res_point, res_count, res_early};

    initial begin
        int  bad;
        bit  found;
        reset_n       = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        cfg_mode      = 1'b0;
        cfg_first_pt  = '0;
        cfg_last_pt   = '0;
        cfg_settle    = '0;
        cfg_window    = '0;
        cfg_err_limit = '0;
        res_ready     = 1'b0;
        model_inc     = 41'd1;

        #2;
        check("reset_outputs", all_outs, 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("idle_after_reset", all_outs, 64'd0);

        // Single point, BER mode.
        cfg_mode = 1'b1; cfg_first_pt = 8'd5; cfg_last_pt = 8'd5;
        cfg_settle = 32'd3; cfg_window = 32'd10; res_ready = 1'b1; model_inc = 41'd1;
        run_sweep(1'b1, 200);
        check("t1_first_clear", 64'(first_clear), 64'd4);
        check("t1_n_clear",     64'(n_clear),     64'd1);
        check("t1_first_en",    64'(first_en),    64'd5);
        check("t1_n_en",        64'(n_en),        64'd10);
        check("t1_last_en",     64'(last_en),     64'd14);
        check("t1_first_valid", 64'(first_valid), 64'd19);
        check("t1_n_valid",     64'(n_valid),     64'd1);
        check("t1_k_done",      64'(k_done),      64'd20);
        check("t1_res_point",   64'(res_pts[0]),  64'd5);
        check("t1_res_count",   64'(res_cnts[0]), 64'd10);
        check("t1_res_early",   64'(res_ers[0]),  64'd0);
        check("t1_ber_mode",    64'(ber_mode),    64'd1);
        check("t1_busy_end",    64'(busy),        64'd0);

        // Three points, zero settle, window 1 then window 0.
        cfg_mode = 1'b0; cfg_first_pt = 8'd2; cfg_last_pt = 8'd4;
        cfg_settle = 32'd0; cfg_window = 32'd1; model_inc = 41'd3;
        for (int w = 1; w >= 0; w--) begin
            cfg_window = 32'(w);
            run_sweep(1'b1, 300);
            check("t2_n_res",    64'(n_res),    64'd3);
            check("t2_pt0",      64'(res_pts[0]), 64'd2);
            check("t2_pt1",      64'(res_pts[1]), 64'd3);
            check("t2_pt2",      64'(res_pts[2]), 64'd4);
            check("t2_cnt0",     64'(res_cnts[0]), 64'd3);
            check("t2_cnt2",     64'(res_cnts[2]), 64'd3);
            check("t2_n_en",     64'(n_en),     64'd3);
            check("t2_n_clear",  64'(n_clear),  64'd3);
            check("t2_k_done",   64'(k_done),   64'd25);
            check("t2_busy_gap", 64'(busy_gap), 64'd0);
        end

        // Backpressure on the first of two points.
        cfg_first_pt = 8'd7; cfg_last_pt = 8'd8; cfg_settle = 32'd1;
        cfg_window = 32'd2; model_inc = 41'd1; res_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1);
            if (res_valid) found = 1'b1;
        end
        check("t3_valid_seen", 64'(found), 64'd1);
        check("t3_res_point",  64'(res_point), 64'd7);
        check("t3_res_count",  64'(res_count), 64'd2);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (res_valid !== 1'b1 || res_point !== 8'd7 || res_count !== 41'd2 || point_code !== 8'd7)
                bad++;
        end
        check("t3_stable", 64'(bad), 64'd0);
        res_ready = 1'b1;
        tick(1);
        check("t3_valid_drop", 64'(res_valid),  64'd0);
        check("t3_advance",    64'(point_code), 64'd8);
        check("t3_busy",       64'(busy),       64'd1);
        run_sweep(1'b0, 200);
        check("t3_n_res",  64'(n_res),       64'd1);
        check("t3_pt8",    64'(res_pts[0]),  64'd8);
        check("t3_cnt8",   64'(res_cnts[0]), 64'd2);

        // Error limit with 2 errors per cycle.
        cfg_mode = 1'b0; cfg_first_pt = 8'h10; cfg_last_pt = 8'h10; cfg_settle = 32'd0;
        cfg_window = 32'd100; cfg_err_limit = 41'd8; model_inc = 41'd2;
        run_sweep(1'b1, 400);
`ifdef BER_EARLY_STOP_EN
        check("t6_n_en",  64'(n_en),        64'd5);
        check("t6_count", 64'(res_cnts[0]), 64'd10);
        check("t6_early", 64'(res_ers[0]),  64'd1);
`else
        check("t6_n_en",  64'(n_en),        64'd100);
        check("t6_count", 64'(res_cnts[0]), 64'd200);
        check("t6_early", 64'(res_ers[0]),  64'd0);
`endif
        check("t6_mode", 64'(ber_mode), 64'd0);
        cfg_err_limit = '0;

        // Abort in the fifth COUNT cycle of ten.
        cfg_mode = 1'b1; cfg_first_pt = 8'd1; cfg_last_pt = 8'd1;
        cfg_settle = 32'd0; cfg_window = 32'd10; model_inc = 41'd1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        check("t4_enable_before", 64'(ber_enable), 64'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t4_enable_off", 64'(ber_enable), 64'd0);
        check("t4_busy_off",   64'(busy),       64'd0);
        check("t4_point_hold", 64'(point_code), 64'd1);
`ifdef BER_EARLY_STOP_EN
        check("t4_count_hold", 64'(res_count),  64'd10);
`else
        check("t4_count_hold", 64'(res_count),  64'd200);
`endif
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (res_valid || done || busy) bad++;
        end
        check("t4_quiet", 64'(bad), 64'd0);
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        check("t4_start_wins", 64'(busy), 64'd1);
        run_sweep(1'b0, 200);
        check("t4_n_en",  64'(n_en),        64'd10);
        check("t4_n_res", 64'(n_res),       64'd1);
        check("t4_count", 64'(res_cnts[0]), 64'd10);

        // Start while busy ignored; asynchronous reset during DRAIN.
        cfg_first_pt = 8'd9; cfg_last_pt = 8'd9; cfg_settle = 32'd0; cfg_window = 32'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        cfg_first_pt = 8'h33;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("t5_start_ignored", 64'(point_code), 64'd9);
        tick(4);
        check("t5_in_drain", 64'({busy, ber_enable, res_valid}), 64'b100);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_reset", all_outs, 64'd0);
        tick(2);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (all_outs !== 64'd0) bad++;
        end
        check("t5_no_result", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
